instr_fetch_unit: RTL and testbench

- Sequential instruction fetcher for the TPU core, directly downstream of the 256x64 instruction SRAM read port (port B).
- Drives enable/address into the SRAM and absorbs its fixed 1-cycle read latency.
- Buffers fetched words in a small prefetch FIFO.
- Presents instructions to the decoder over a valid/ready handshake, with support for start, halt and PC redirect.

---
 rtl/instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher between the port-B read of the instruction SRAM and the decoder.
// Latency: start to first instr_valid is 2 cycles (a response bypasses an empty FIFO), then 1 instr/cycle.
// Backpressure: instr_ready low fills the FIFO; no read is issued once FIFO entries + in-flight read reach FIFO_DEPTH.
//
// Ports: clk/rst_n (async active-low); start/start_pc, halt, redirect_valid/redirect_pc control inputs;
//        imem_en/imem_addr/imem_rdata SRAM read port (1-cycle latency); instr_valid/instr_ready/
//        instr_data/instr_pc decoder handshake; busy (not IDLE), done (end-of-memory drain finished).

// Generic flushable FIFO, power-of-two depth. The writer must respect count; a push into a full FIFO is not guarded.
module ifu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_vld,
  input  logic [W-1:0]             in_dat,
  input  logic                     out_rdy,
  output logic                     out_vld,
  output logic [W-1:0]             out_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push, pop;

  assign out_vld = (cnt_q != '0);
  assign out_dat = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push     = in_vld;
    pop      = out_vld && out_rdy;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module instr_fetch_unit #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] dat;
  } fetch_ent_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;

  logic              flush;
  logic              resp_vld;
  logic              room;
  logic              issue;
  logic              bypass_take;
  logic              fifo_push;
  logic              fifo_vld;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    used;
  fetch_ent_t        resp_ent;
  fetch_ent_t        fifo_head;

  // Halt or redirect while active discards everything fetched so far. The only read that
  // can be outstanding is the one whose data arrives this very cycle, so dropping it here
  // is sufficient: nothing is issued in a flush cycle.
  assign flush    = (state_q != S_IDLE) && (halt || redirect_valid);
  assign resp_vld = inflight_q && !flush;
  assign resp_ent = '{pc: tag_q, dat: imem_rdata};

  // Credit: a read is only issued if its response is guaranteed a FIFO slot.
  assign used = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight_q};
  assign room = (used < DEPTH_C);

  // An arriving response goes straight to the decoder when the FIFO is empty and the
  // decoder takes it; otherwise it is queued behind the current head.
  assign bypass_take = resp_vld && !fifo_vld && instr_ready;
  assign fifo_push   = resp_vld && !bypass_take;

  ifu_fifo #(
    .W     ($bits(fetch_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .in_vld  (fifo_push),
    .in_dat  (resp_ent),
    .out_rdy (instr_ready && !flush),
    .out_vld (fifo_vld),
    .out_dat (fifo_head),
    .count   (fifo_cnt)
  );

  assign instr_valid = (fifo_vld && !flush) || resp_vld;

  always_comb begin
    instr_pc   = '0;
    instr_data = '0;
    if (fifo_vld) begin
      instr_pc   = fifo_head.pc;
      instr_data = fifo_head.dat;
    end else if (resp_vld) begin
      instr_pc   = resp_ent.pc;
      instr_data = resp_ent.dat;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    done_d     = 1'b0;
    issue      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = start_pc;
        end
      end
      S_FETCH: begin
        if (halt) begin
          state_d = S_IDLE;
        end else if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (room) begin
          issue      = 1'b1;
          inflight_d = 1'b1;
          tag_d      = pc_q;
          // The last address ends the run; pc stays there rather than wrapping to 0.
          if (pc_q == '1) begin
            state_d = S_DRAIN;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (halt) begin
          state_d = S_IDLE;
        end else if (redirect_valid) begin
          state_d = S_FETCH;
          pc_d    = redirect_pc;
        end else if (!fifo_vld && !inflight_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  assign imem_en   = issue;
  assign imem_addr = pc_q;
  // done is registered, so it rises in the first IDLE cycle, exactly when busy falls.
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int AW = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n, start, halt, redirect_valid, instr_ready;
  logic          imem_en, instr_valid, busy, done;
  logic [AW-1:0] start_pc, redirect_pc, imem_addr, instr_pc;
  logic [DW-1:0] imem_rdata, instr_data;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .start_pc       (start_pc),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .busy           (busy),
    .done           (done)
  );

  // Instruction SRAM port B: registered read, 1-cycle latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] dat; } exp_t;
  typedef struct { logic [AW-1:0] start_pc; int ready_pct; int exp_n; int exp_lat; } vec_t;

  exp_t          sb[$];
  logic [AW-1:0] issue_log[$];
  vec_t          vec [5];

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, n_issue = 0, n_done = 0, n_deliv = 0, first_valid = -1, last_deliv = -1;
  int   ready_mode = 0, ready_pct = 100;
  logic last_valid, last_en, last_busy, last_done, prev_busy, done_busy, done_prev_busy;
  logic [AW-1:0] last_pc;

  function automatic logic [DW-1:0] img(input logic [AW-1:0] a);
    return 64'(a) * 64'h0101;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic apply_ready();
    case (ready_mode)
      0:       instr_ready = 1'b0;
      1:       instr_ready = 1'b1;
      default: instr_ready = (sb.size() > 0) && (int'($urandom_range(0, 99)) < ready_pct);
    endcase
  endtask

  task automatic set_ready(input int m, input int p);
    ready_mode = m;
    ready_pct  = p;
    apply_ready();
  endtask

  task automatic clear_stats();
    n_issue = 0; n_done = 0; n_deliv = 0; first_valid = -1; last_deliv = -1;
    issue_log.delete();
  endtask

  task automatic expect_pc(input logic [AW-1:0] a);
    exp_t e;
    e.pc  = a;
    e.dat = img(a);
    sb.push_back(e);
  endtask

  // Monitor: observes the cycle on the falling edge, consuming the scoreboard on each handshake.
  task automatic sample();
    exp_t e;
    cyc++;
    last_valid = instr_valid; last_en = imem_en; last_busy = busy;
    last_done  = done;        last_pc = instr_pc;
    if (imem_en) begin n_issue++; issue_log.push_back(imem_addr); end
    if (instr_valid && first_valid < 0) first_valid = cyc;
    if (done) begin n_done++; done_busy = busy; done_prev_busy = prev_busy; end
    prev_busy = busy;
    if (rst_n && instr_valid && instr_ready) begin
      n_deliv++;
      last_deliv = cyc;
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL deliver_unexpected: got pc %0h, required no delivery", instr_pc);
      end else begin
        e = sb.pop_front();
        check("deliver_pc", instr_pc, e.pc);
        check("deliver_data", instr_data, e.dat);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    apply_ready();
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    start = 1'b1; start_pc = a; step(); start = 1'b0;
  endtask

  task automatic pulse_halt();
    halt = 1'b1; step(); halt = 1'b0;
  endtask

  task automatic drain_sb(input string name, input int budget);
    int k = 0;
    while (sb.size() > 0 && k < budget) begin step(); k++; end
    check(name, sb.size(), 0);
  endtask

  function automatic logic [AW-1:0] issue_at(input int i);
    return (i < issue_log.size()) ? issue_log[i] : 'x;
  endfunction

  task automatic run_vec(input vec_t v);
    int c0, k;
    sb.delete(); clear_stats();
    for (int a = int'(v.start_pc); a < 256; a++) expect_pc(AW'(a));
    set_ready(2, v.ready_pct);
    pulse_start(v.start_pc);
    c0 = cyc;
    k = 0;
    while (n_done == 0 && k < 3000) begin step(); k++; end
    repeat (4) step();
    check("vec_done_count", n_done, 1);
    check("vec_delivered", n_deliv, v.exp_n);
    check("vec_issued", n_issue, v.exp_n);
    check("vec_sb_empty", sb.size(), 0);
    check("vec_busy_at_done", done_busy, 0);
    check("vec_busy_before_done", done_prev_busy, 1);
    check("vec_busy_after", last_busy, 0);
    if (v.exp_lat >= 0) begin
      check("vec_first_latency", first_valid - c0, v.exp_lat);
      check("vec_back_to_back", last_deliv - first_valid, v.exp_n - 1);
    end
  endtask

  initial begin
    bit pc_stable;
    vec[0] = '{8'hFC, 100,   4,  2};
    vec[1] = '{8'hFE, 100,   2,  2};
    vec[2] = '{8'hFF, 100,   1,  2};
    vec[3] = '{8'hE0,  40,  32, -1};
    vec[4] = '{8'h00,  60, 256, -1};
    for (int i = 0; i < 256; i++) mem[i] = img(AW'(i));

    rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    start_pc = '0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_en", imem_en, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_data", instr_data, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(vec[i]);

    // Backpressure: only two reads fit, head stays put, then in-order release.
    sb.delete(); clear_stats(); set_ready(0, 0);
    pulse_start(8'h10);
    pc_stable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i >= 1 && (!last_valid || last_pc != 8'h10)) pc_stable = 1'b0;
    end
    check("stall_issue_count", n_issue, 2);
    check("stall_addr0", issue_at(0), 8'h10);
    check("stall_addr1", issue_at(1), 8'h11);
    check("stall_en_low", last_en, 0);
    check("stall_head_stable", pc_stable, 1);
    expect_pc(8'h10); expect_pc(8'h11); expect_pc(8'h12);
    set_ready(2, 100);
    drain_sb("stall_release", 40);
    pulse_halt();
    step();
    check("stall_halt_busy", last_busy, 0);

    // Redirect while the response for 0x05 is arriving.
    sb.delete(); clear_stats(); set_ready(0, 0);
    pulse_start(8'h04);
    step(); step();
    check("redir_inflight_addr", issue_at(n_issue - 1), 8'h05);
    redirect_valid = 1'b1; redirect_pc = 8'h40; step(); redirect_valid = 1'b0;
    check("redir_no_issue", last_en, 0);
    expect_pc(8'h40); expect_pc(8'h41); expect_pc(8'h42);
    set_ready(2, 100);
    step();
    check("redir_valid_after", last_valid, 0);
    drain_sb("redir_stream", 40);
    pulse_halt();
    step();

    // Halt with one FIFO entry and one read outstanding.
    sb.delete(); clear_stats(); set_ready(0, 0);
    pulse_start(8'h30);
    step(); step();
    pulse_halt();
    check("halt_no_issue_cycle", last_en, 0);
    set_ready(1, 0);
    step();
    check("halt_valid_next", last_valid, 0);
    check("halt_busy", last_busy, 0);
    check("halt_done", last_done, 0);
    repeat (5) step();
    check("halt_issue_total", n_issue, 2);
    check("halt_done_never", n_done, 0);
    expect_pc(8'h20); expect_pc(8'h21);
    set_ready(2, 100);
    pulse_start(8'h20);
    drain_sb("halt_restart", 40);
    pulse_halt();
    step();

    // Asynchronous reset mid-fetch.
    sb.delete(); clear_stats(); set_ready(0, 0);
    pulse_start(8'h50);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_imem_en", imem_en, 0);
    check("arst_instr_valid", instr_valid, 0);
    check("arst_instr_pc", instr_pc, 0);
    check("arst_instr_data", instr_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    step();
    rst_n = 1'b1;
    clear_stats(); set_ready(1, 0);
    repeat (8) step();
    check("arst_no_valid_after", first_valid, -1);
    check("arst_no_issue_after", n_issue, 0);
    check("arst_busy_after", last_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
